window_std_dev_seq: RTL and testbench

Sequential, handshaked replacement for the combinational window standard-deviation path in the face-detect pipeline. It accepts the four corner values of the integral and squared-integral images for one scan window and forms the variance term `WIN_AREA*sq_sum - sum*sum` using one registered multiply. It then resolves the square root with a 16-iteration bit-serial unit and returns the result to the classifier-stage scheduler over a valid/ready interface. One window is in flight at a time.

---
 rtl/vj_pkg.sv | 22 ++
 rtl/isqrt_iter.sv | 57 +++++
 rtl/window_std_dev_seq.sv | 103 ++++++++++
 tb/tb_window_std_dev_seq.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vj_pkg.sv
// Shared types and constants for the face-detect
// window statistics blocks.
`ifndef WINDOW_SIZE
`define WINDOW_SIZE 24
`endif

package vj_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SQRT,
    DONE
  } std_state_t;

  localparam int SQRT_ITERS = 16;
  localparam int STD_W = 32;

  localparam int WINDOW_SIZE = `WINDOW_SIZE;
  localparam int WIN_AREA_DEF = WINDOW_SIZE * WINDOW_SIZE;

endpackage

// File: rtl/isqrt_iter.sv
// Restoring bit-serial integer square root,
// one root bit per step, MSB first.
module isqrt_iter
  import vj_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [STD_W-1:0] radicand,
  output logic             last,
  output logic             done,
  output logic [15:0]      root
);

  logic [3:0]  cnt;
  logic [15:0] root_q;
  logic [17:0] rem_q;
  logic [17:0] rem_nxt;
  logic [19:0] rem_sh;
  logic [19:0] trial;
  logic [1:0]  pair;

  assign last = (cnt == 4'd0);

  always_comb begin
    pair    = radicand[{cnt, 1'b0} +: 2];
    rem_sh  = {rem_q, pair};
    trial   = {2'b00, root_q, 2'b01};
    rem_nxt = rem_sh[17:0];
    root    = {root_q[14:0], 1'b0};
    if (rem_sh >= trial) begin
      rem_nxt = 18'(rem_sh - trial);
      root    = {root_q[14:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      root_q <= '0;
      rem_q  <= '0;
      done   <= 1'b0;
    end else if (load) begin
      cnt    <= 4'(SQRT_ITERS - 1);
      root_q <= '0;
      rem_q  <= '0;
      done   <= 1'b0;
    end else if (step && !done) begin
      cnt    <= cnt - 4'd1;
      root_q <= root;
      rem_q  <= rem_nxt;
      done   <= last;
    end
  end

endmodule

// File: rtl/window_std_dev_seq.sv
// Sequential window standard deviation: corner
// arithmetic, variance multiply, serial sqrt.
module window_std_dev_seq
  import vj_pkg::*;
#(
  parameter int WIN_AREA = WIN_AREA_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] tl,
  input  logic [31:0] tr,
  input  logic [31:0] bl,
  input  logic [31:0] br,
  input  logic [31:0] tl_sq,
  input  logic [31:0] tr_sq,
  input  logic [31:0] bl_sq,
  input  logic [31:0] br_sq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] std_dev,
  output logic        busy
);

  std_state_t state;
  std_state_t state_nxt;

  logic [31:0] sum_q;
  logic [31:0] sq_q;
  logic [31:0] var_q;
  logic [31:0] var_c;
  logic [31:0] area_sq;
  logic [31:0] std_q;

  logic        sq_load;
  logic        sq_step;
  logic        sq_last;
  logic        sq_done;
  logic [15:0] sq_root;

  always_comb begin
    if (WIN_AREA == 576) begin
      area_sq = (sq_q << 9) + (sq_q << 6);
    end else begin
      area_sq = sq_q * 32'(WIN_AREA);
    end
    var_c = area_sq - sum_q * sum_q;
  end

  assign sq_load = (state == CALC);
  assign sq_step = (state == SQRT);

  isqrt_iter u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sq_load),
    .step     (sq_step),
    .radicand (var_q),
    .last     (sq_last),
    .done     (sq_done),
    .root     (sq_root)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: state_nxt = SQRT;
      SQRT: if (sq_last && !sq_done) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sum_q <= '0;
      sq_q  <= '0;
      var_q <= '0;
      std_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        sum_q <= br - bl + tl - tr;
        sq_q  <= br_sq - bl_sq + tl_sq - tr_sq;
      end
      if (state == CALC) begin
        var_q <= var_c;
      end
      if (state == SQRT && sq_last && !sq_done) begin
        std_q <= {16'b0, sq_root};
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign std_dev   = std_q;

endmodule

// File: tb/tb_window_std_dev_seq.sv
// Scoreboard bench for window_std_dev_seq.
module tb_window_std_dev_seq;

  localparam int AREA = 576;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] tl = '0, tr = '0, bl = '0, br = '0;
  logic [31:0] tl_sq = '0, tr_sq = '0;
  logic [31:0] bl_sq = '0, br_sq = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [31:0] std_dev;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  window_std_dev_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tl        (tl),
    .tr        (tr),
    .bl        (bl),
    .br        (br),
    .tl_sq     (tl_sq),
    .tr_sq     (tr_sq),
    .bl_sq     (bl_sq),
    .br_sq     (br_sq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .std_dev   (std_dev),
    .busy      (busy)
  );

  function automatic logic [31:0] model(
    input logic [31:0] a, b, c, d,
    input logic [31:0] e, f, g, h);
    logic [31:0] s, q, v;
    logic [63:0] r, t;
    s = d - c + a - b;
    q = h - g + e - f;
    v = 32'(AREA) * q - s * s;
    r = 0;
    for (int k = 15; k >= 0; k--) begin
      t = r | (64'd1 << k);
      if (t * t <= {32'b0, v}) r = t;
    end
    return r[31:0];
  endfunction

  task automatic drive(
    input logic [31:0] a, b, c, d,
    input logic [31:0] e, f, g, h);
    tl = a; tr = b; bl = c; br = d;
    tl_sq = e; tr_sq = f; bl_sq = g; br_sq = h;
  endtask

  task automatic accept(
    input logic [31:0] a, b, c, d,
    input logic [31:0] e, f, g, h);
    drive(a, b, c, d, e, f, g, h);
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(a, b, c, d, e, f, g, h));
    @(negedge clk);
    in_valid = 1'b0;
    drive($urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    @(negedge clk);
    @(negedge clk);
    got = {28'b0, in_ready, out_valid, busy, 1'b0};
    checks++;
    if (got !== 32'h8) begin
      $display("FAIL rst_flags got=%h exp=8", got);
      errors++;
    end
    checks++;
    if (std_dev !== 32'd0) begin
      $display("FAIL rst_std got=%0d exp=0", std_dev);
      errors++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL rel_flags rdy=%b busy=%b exp 1/0",
               in_ready, busy);
      errors++;
    end
  endtask

  task automatic test_zero();
    int lat;
    logic [31:0] exp;
    accept(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL calc_flags busy=%b rdy=%b exp 1/0",
               busy, in_ready);
      errors++;
    end
    wait_out(lat);
    checks++;
    if (lat != 18) begin
      $display("FAIL zero_lat got=%0d exp=18", lat);
      errors++;
    end
    exp = sb.pop_front();
    checks++;
    if (std_dev !== exp || std_dev !== 32'd0) begin
      $display("FAIL zero_std got=%0d exp=%0d", std_dev, exp);
      errors++;
    end
    take();
  endtask

  task automatic test_values();
    logic [31:0] vb[3]  = '{32'd100, 32'd0, 32'd1};
    logic [31:0] vbs[3] = '{32'd1000, 32'd4, 32'd0};
    logic [31:0] lit[3] = '{32'd752, 32'd48, 32'd65535};
    int lat;
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      accept(0, 0, 0, vb[i], 0, 0, 0, vbs[i]);
      wait_out(lat);
      checks++;
      if (lat != 18) begin
        $display("FAIL val%0d_lat got=%0d exp=18", i, lat);
        errors++;
      end
      exp = sb.pop_front();
      checks++;
      if (std_dev !== exp) begin
        $display("FAIL val%0d_model got=%0d exp=%0d",
                 i, std_dev, exp);
        errors++;
      end
      checks++;
      if (std_dev !== lit[i]) begin
        $display("FAIL val%0d_lit got=%0d exp=%0d",
                 i, std_dev, lit[i]);
        errors++;
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] v0, exp;
    accept(5, 2, 7, 20, 50, 10, 30, 900);
    wait_out(lat);
    v0 = std_dev;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        drive(1, 0, 0, 9, 0, 0, 0, 77);
        in_valid = 1'b1;
      end
      if (i == 3) in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || std_dev !== v0 ||
          in_ready !== 1'b0) begin
        $display("FAIL bp_hold%0d ov=%b std=%0d rdy=%b exp 1/%0d/0",
                 i, out_valid, std_dev, in_ready, v0);
        errors++;
      end
    end
    exp = sb.pop_front();
    checks++;
    if (std_dev !== exp) begin
      $display("FAIL bp_std got=%0d exp=%0d", std_dev, exp);
      errors++;
    end
    drive(3, 1, 4, 60, 9, 2, 40, 5000);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL bp_release rdy=%b ov=%b exp 1/0",
               in_ready, out_valid);
      errors++;
    end
    @(posedge clk);
    sb.push_back(model(3, 1, 4, 60, 9, 2, 40, 5000));
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL bp_reaccept busy=%b exp=1", busy);
      errors++;
    end
    wait_out(lat);
    checks++;
    if (lat != 18) begin
      $display("FAIL bp_lat got=%0d exp=18", lat);
      errors++;
    end
    exp = sb.pop_front();
    checks++;
    if (std_dev !== exp) begin
      $display("FAIL bp_std2 got=%0d exp=%0d", std_dev, exp);
      errors++;
    end
    take();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    fork
      begin
        logic [31:0] c[8];
        for (int w = 0; w < 4; w++) begin
          int t = 0;
          foreach (c[j]) c[j] = $urandom;
          drive(c[0], c[1], c[2], c[3],
                c[4], c[5], c[6], c[7]);
          in_valid = 1'b1;
          while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
          end
          @(posedge clk);
          sb.push_back(model(c[0], c[1], c[2], c[3],
                             c[4], c[5], c[6], c[7]));
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        logic [31:0] exp;
        for (int w = 0; w < 4; w++) begin
          int t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (!out_valid && t < 100);
          exp = (sb.size() != 0) ? sb.pop_front() : 32'hx;
          checks++;
          if (!out_valid || std_dev !== exp) begin
            $display("FAIL b2b%0d ov=%b got=%0d exp=%0d",
                     w, out_valid, std_dev, exp);
            errors++;
          end
        end
      end
    join
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat;
    logic [31:0] exp;
    accept(0, 0, 0, 100, 0, 0, 0, 1000);
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL abort_busy got=%b exp=1", busy);
      errors++;
    end
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        busy !== 1'b0 || std_dev !== 32'd0) begin
      $display("FAIL abort_rst rdy=%b ov=%b busy=%b std=%0d",
               in_ready, out_valid, busy, std_dev);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept(0, 0, 0, 0, 0, 0, 0, 4);
    wait_out(lat);
    checks++;
    if (lat != 18) begin
      $display("FAIL abort_lat got=%0d exp=18", lat);
      errors++;
    end
    exp = sb.pop_front();
    checks++;
    if (std_dev !== exp || std_dev !== 32'd48) begin
      $display("FAIL abort_std got=%0d exp=%0d", std_dev, exp);
      errors++;
    end
    take();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_backpressure();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
